// File: rtl/frost32_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : PkgFrost32Cpu
// Description : Shared Frost32 CPU data-port types plus the memory responder
//               state encoding and lane/alignment helpers.
// Revision    : 1.0 - initial memory responder additions
// ============================================================================
package PkgFrost32Cpu;

    // Direction of a data-port access
    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } DataInoutAccessType;

    // Width of a data-port access
    typedef enum logic [1:0] {
        Dias32  = 2'd0,
        Dias16  = 2'd1,
        Dias8   = 2'd2,
        DiasBad = 2'd3
    } DataInoutAccessSize;

    // Memory responder sequencing
    typedef enum logic [1:0] {
        MrsIdle = 2'd0,
        MrsBusy = 2'd1,
        MrsDone = 2'd2
    } MemResponderState;

    // Little-endian byte lanes touched by an access of the given size
    function automatic logic [3:0] lane_enables(input DataInoutAccessSize size,
                                                input logic [1:0] lane);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            Dias32:  mask = 4'b1111;
            Dias16:  mask = lane[1] ? 4'b1100 : 4'b0011;
            Dias8:   mask = 4'b0001 << lane;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Natural alignment rule; the bad size is never legal
    function automatic logic is_aligned(input DataInoutAccessSize size,
                                        input logic [1:0] lane);
        logic ok;
        ok = 1'b0;
        case (size)
            Dias32:  ok = (lane == 2'b00);
            Dias16:  ok = (lane[0] == 1'b0);
            Dias8:   ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frost32_byte_lane_ram.sv
`default_nettype none
// ============================================================================
// Module      : frost32_byte_lane_ram
// Description : Single-port 32-bit word RAM with per-byte write enables and a
//               registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module frost32_byte_lane_ram #(
    parameter int    ADDR_W        = 12,
    parameter string MEM_INIT_FILE = ""
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_we,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [31:0] r_mem [0:c_DEPTH-1];
    logic [31:0] r_rdata;

    // Byte-masked write and read-before-write registered read
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/frost32_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : frost32_mem_responder
// Description : Memory-side responder for the Frost32 data port. Latches a
//               request, waits a configurable latency, then performs an
//               alignment-checked byte-lane access on the backing RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module frost32_mem_responder
    import PkgFrost32Cpu::*;
#(
    parameter int    MEM_WORDS_LOG2 = 12,
    parameter int    READ_LATENCY   = 2,
    parameter int    WRITE_LATENCY  = 1,
    parameter string MEM_INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_mem_access,
    input  logic [31:0] addr,
    input  logic        data_inout_access_type,
    input  logic [1:0]  data_inout_access_size,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        wait_for_mem,
    output logic        bus_error
);

    localparam int c_MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(READ_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LOAD = c_CNT_W'(WRITE_LATENCY - 1);

    MemResponderState   r_state;
    MemResponderState   w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [MEM_WORDS_LOG2-1:0] r_index;
    logic [1:0]         r_lane;
    DataInoutAccessType r_type;
    DataInoutAccessSize r_size;
    logic [31:0]        r_wr_data;

    DataInoutAccessType w_req_type;
    DataInoutAccessSize w_req_size;
    logic               w_start;
    logic               w_finish;
    logic               w_legal;
    logic [3:0]         w_byte_en;
    logic [31:0]        w_wr_lanes;
    logic [31:0]        w_ram_rdata;
    logic [31:0]        w_rd_shifted;
    logic [31:0]        w_rd_steered;
    logic [MEM_WORDS_LOG2-1:0] w_ram_index;
    logic               w_unused_addr_bits;

    assign w_req_type = DataInoutAccessType'(data_inout_access_type);
    assign w_req_size = DataInoutAccessSize'(data_inout_access_size);

    // Upper address bits alias onto the RAM and are deliberately dropped
    assign w_unused_addr_bits = ^addr[31:MEM_WORDS_LOG2+2];

    assign wait_for_mem = (r_state == MrsBusy) | ((r_state == MrsIdle) & req_mem_access);
    assign w_legal      = is_aligned(r_size, r_lane);

    // Next-state decode; start/finish flag the Idle->Busy and Busy->Done edges
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            MrsIdle: begin
                if (req_mem_access) begin
                    w_state_nxt = MrsBusy;
                    w_start     = 1'b1;
                end
            end
            MrsBusy: begin
                if (r_cnt == '0) begin
                    w_state_nxt = MrsDone;
                    w_finish    = 1'b1;
                end
            end
            MrsDone: w_state_nxt = MrsIdle;
            default: w_state_nxt = MrsIdle;
        endcase
    end

    // In Idle the RAM is addressed from the live bus so its registered output
    // is already valid in the first Busy cycle, even for a latency of 1
    assign w_ram_index = (r_state == MrsIdle) ? addr[MEM_WORDS_LOG2+1:2] : r_index;

    // Replicate narrow store data across all lanes; the enables pick the lane
    always_comb begin
        w_wr_lanes = r_wr_data;
        case (r_size)
            Dias16:  w_wr_lanes = {2{r_wr_data[15:0]}};
            Dias8:   w_wr_lanes = {4{r_wr_data[7:0]}};
            default: w_wr_lanes = r_wr_data;
        endcase
    end

    assign w_byte_en = (w_finish && (r_type == DiatWrite) && w_legal)
                     ? lane_enables(r_size, r_lane) : 4'b0000;

    // Shift the addressed lanes down to bit 0 and zero-extend
    assign w_rd_shifted = w_ram_rdata >> {r_lane, 3'b000};
    always_comb begin
        w_rd_steered = w_ram_rdata;
        case (r_size)
            Dias16:  w_rd_steered = {16'h0000, w_rd_shifted[15:0]};
            Dias8:   w_rd_steered = {24'h000000, w_rd_shifted[7:0]};
            default: w_rd_steered = w_ram_rdata;
        endcase
    end

    // State, latency counter, latched request and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= MrsIdle;
            r_cnt     <= '0;
            r_index   <= '0;
            r_lane    <= 2'b00;
            r_type    <= DiatRead;
            r_size    <= Dias32;
            r_wr_data <= '0;
            rd_data   <= '0;
            bus_error <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            bus_error <= w_finish & ~w_legal;
            if (w_start) begin
                r_cnt     <= (w_req_type == DiatWrite) ? c_WR_LOAD : c_RD_LOAD;
                r_index   <= addr[MEM_WORDS_LOG2+1:2];
                r_lane    <= addr[1:0];
                r_type    <= w_req_type;
                r_size    <= w_req_size;
                r_wr_data <= wr_data;
            end else if ((r_state == MrsBusy) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_finish && (r_type == DiatRead)) begin
                rd_data <= w_legal ? w_rd_steered : 32'h0;
            end
        end
    end

    frost32_byte_lane_ram #(
        .ADDR_W        (MEM_WORDS_LOG2),
        .MEM_INIT_FILE (MEM_INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_index),
        .i_we    (w_byte_en),
        .i_wdata (w_wr_lanes),
        .o_rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_frost32_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_frost32_mem_responder
// Description : Scoreboard bench for the Frost32 memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frost32_mem_responder;
    import PkgFrost32Cpu::*;

    localparam int c_RL = 2;
    localparam int c_WL = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_mem_access = 1'b0;
    logic [31:0] addr = '0;
    logic        data_inout_access_type = 1'b0;
    logic [1:0]  data_inout_access_size = 2'd0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        wait_for_mem;
    logic        bus_error;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic [7:0]  lat;
        logic [7:0]  id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   lat_cnt = 0;
    int   vec_id = 0;
    bit   prev_hold = 1'b0;

    frost32_mem_responder #(
        .MEM_WORDS_LOG2 (12),
        .READ_LATENCY   (c_RL),
        .WRITE_LATENCY  (c_WL),
        .MEM_INIT_FILE  ("")
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .req_mem_access         (req_mem_access),
        .addr                   (addr),
        .data_inout_access_type (data_inout_access_type),
        .data_inout_access_size (data_inout_access_size),
        .wr_data                (wr_data),
        .rd_data                (rd_data),
        .wait_for_mem           (wait_for_mem),
        .bus_error              (bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles of a request and scores the completion cycle
    always @(negedge clk) begin
        if (!rst_n || !req_mem_access) begin
            lat_cnt = 0;
        end else if (wait_for_mem) begin
            lat_cnt++;
        end else begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got a completion, expected none");
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("v%0d rd_data", mon_e.id), rd_data, mon_e.rd);
                check($sformatf("v%0d bus_error", mon_e.id), {31'b0, bus_error}, {31'b0, mon_e.err});
                check($sformatf("v%0d wait_cycles", mon_e.id), 32'(lat_cnt), {24'b0, mon_e.lat});
            end
            lat_cnt = 0;
        end
    end

    // Drive one request; hold keeps req high so the next request follows in Done
    task automatic issue(input logic typ, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd,
                         input logic exp_err, input bit scramble, input bit hold);
        exp_t e;
        bit   done;
        e.rd  = exp_rd;
        e.err = exp_err;
        e.lat = 8'((typ ? c_WL : c_RL) + 1);
        e.id  = 8'(vec_id);
        vec_id++;
        if (!prev_hold) begin
            @(posedge clk);
            #1;
        end
        exp_q.push_back(e);
        req_mem_access         = 1'b1;
        data_inout_access_type = typ;
        data_inout_access_size = sz;
        addr                   = a;
        wr_data                = d;
        done = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(posedge clk);
            #1;
            if (scramble && cyc == 0) begin
                addr                   = ~a;
                wr_data                = ~d;
                data_inout_access_type = ~typ;
                data_inout_access_size = sz ^ 2'b01;
            end
            if (!wait_for_mem) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL v%0d timeout: got no completion, expected one within 20 cycles", e.id);
        end
        prev_hold = hold;
        if (!hold) begin
            @(negedge clk);
            #1;
            req_mem_access = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset rd_data", rd_data, 32'h0);
        check("reset bus_error", {31'b0, bus_error}, 32'h0);
        check("reset wait_for_mem", {31'b0, wait_for_mem}, 32'h0);
        rst_n = 1'b1;

        //    type       size  addr           wr_data        exp rd_data    err  scr hold
        issue(DiatWrite, 2'd0, 32'h0000_0020, 32'h0BAD_F00D, 32'h0000_0000, 0, 0, 0);
        issue(DiatRead,  2'd0, 32'h0000_0020, 32'h0,         32'h0BAD_F00D, 0, 0, 0);

        // Interrupted write: reset lands while the write is in Busy
        @(posedge clk);
        #1;
        req_mem_access         = 1'b1;
        data_inout_access_type = DiatWrite;
        data_inout_access_size = 2'd0;
        addr                   = 32'h0000_0020;
        wr_data                = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("busy wait_for_mem", {31'b0, wait_for_mem}, 32'h1);
        rst_n          = 1'b0;
        req_mem_access = 1'b0;
        #1;
        check("async reset wait_for_mem", {31'b0, wait_for_mem}, 32'h0);
        check("async reset rd_data", rd_data, 32'h0);
        check("async reset bus_error", {31'b0, bus_error}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prev_hold = 1'b0;

        issue(DiatRead,  2'd0, 32'h0000_0020, 32'h0,         32'h0BAD_F00D, 0, 0, 0);
        issue(DiatWrite, 2'd0, 32'h0000_0040, 32'h1122_3344, 32'h0BAD_F00D, 0, 0, 0);
        issue(DiatRead,  2'd0, 32'h0000_0040, 32'h0,         32'h1122_3344, 0, 0, 0);
        issue(DiatWrite, 2'd2, 32'h0000_0041, 32'hFFFF_FFAA, 32'h1122_3344, 0, 0, 0);
        issue(DiatWrite, 2'd1, 32'h0000_0042, 32'h1234_BEEF, 32'h1122_3344, 0, 1, 0);
        issue(DiatRead,  2'd0, 32'h0000_0040, 32'h0,         32'hBEEF_AA44, 0, 0, 0);
        issue(DiatRead,  2'd2, 32'h0000_0043, 32'h0,         32'h0000_00BE, 0, 0, 0);
        issue(DiatRead,  2'd1, 32'h0000_0042, 32'h0,         32'h0000_BEEF, 0, 0, 0);
        issue(DiatRead,  2'd2, 32'h0000_0040, 32'h0,         32'h0000_0044, 0, 0, 0);
        issue(DiatWrite, 2'd0, 32'h0000_0042, 32'hCAFE_F00D, 32'h0000_0044, 1, 0, 0);
        issue(DiatRead,  2'd3, 32'h0000_0040, 32'h0,         32'h0000_0000, 1, 0, 0);
        issue(DiatRead,  2'd1, 32'h0000_0041, 32'h0,         32'h0000_0000, 1, 0, 0);
        issue(DiatWrite, 2'd1, 32'h0000_0041, 32'h0000_9999, 32'h0000_0000, 1, 0, 0);
        issue(DiatRead,  2'd0, 32'h0000_0040, 32'h0,         32'hBEEF_AA44, 0, 0, 0);
        issue(DiatWrite, 2'd0, 32'h0000_4040, 32'h5566_7788, 32'hBEEF_AA44, 0, 0, 1);
        issue(DiatRead,  2'd0, 32'h0000_0040, 32'h0,         32'h5566_7788, 0, 0, 1);
        issue(DiatRead,  2'd2, 32'h0000_4042, 32'h0,         32'h0000_0066, 0, 0, 0);

        repeat (4) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
